four_12_12_st0_tap_sched: RTL and testbench
===========================================

FOUR_12_12_ST0_TAP_SCHED -- requirements
Module: four_12_12_st0_tap_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all registers update on the rising edge of clk only.
REQ-002 Parameter NTAP, default 12: number of tap rows per pass.
REQ-003 Parameter DRAIN, default 5: pipeline drain cycles, equal to the tap write-back latency.
REQ-004 The ports SHALL be, in this order:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- fwd_start  in  1  pulse; request a forward (inference) pass.
- err_start  in  1  pulse; request an error-update pass.
- stall  in  1  downstream not ready; freezes address issue.
- tap_address  out  5  tap/bias row read address.
- tap_enable  out  1  row issue in an error pass; gates tap write-back.
- active_normal  out  1  row issue in any pass; memory read valid.
- active_start_d  out  1  one-cycle pulse on the first issued row of a forward pass.
- error_update_first  out  1  high for the single ERR_FIRST cycle.
- error_update_latch  out  1  high on every issued row of an error pass.
- error_phase  out  4  current error phase, 0..NTAP-1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of DRAIN.
- req_drop  out  1  sticky; a request was lost.

Function
REQ-005 The FSM SHALL have five states: IDLE, FWD, ERR_FIRST, ERR and DRAIN.
REQ-006 IDLE exit rules:
- fwd_start or a pending forward request -> FWD.
- Otherwise, err_start or a pending error request -> ERR_FIRST.
- Forward has priority; a simultaneous err_start becomes pending.
REQ-007 FWD row issue:
- Each cycle with stall=0: active_normal=1, tap_address = row counter, counter increments.
- active_start_d=1 on row 0 only.
- After row NTAP-1 is issued, next state is DRAIN.
REQ-008 ERR_FIRST lasts exactly one cycle, independent of stall:
- error_update_first=1.
- tap_address = 12 + error_phase, the accumulator row.
- active_normal=1.
- Next state is ERR.
REQ-009 ERR row issue:
- Same row sequencing as FWD.
- Each issued row asserts tap_enable=1 and error_update_latch=1.
- After row NTAP-1, next state is DRAIN.
REQ-010 Stall: while stall=1 in FWD or ERR:
- tap_address holds its value.
- active_normal, tap_enable, error_update_latch and active_start_d are 0.
- The row counter does not advance.
REQ-011 DRAIN SHALL count exactly DRAIN cycles, ignoring stall, then pulse done=1 for one cycle and return to IDLE on that same cycle.
REQ-012 Error phase:
- error_phase increments by 1 when done pulses at the end of an error pass.
- It wraps from NTAP-1 to 0.
- It is unchanged by forward passes.
REQ-013 Request storage while busy or blocked:
- fwd_start or err_start arriving while busy SHALL set a one-deep pending flag for that request type.
- A request arriving while its flag is already set SHALL set req_drop.
- A pending flag clears when its pass leaves IDLE.
REQ-014 A pending request SHALL be serviced on the first IDLE cycle, with the same priority as REQ-006.
REQ-015 tap_address SHALL be 0 in IDLE and DRAIN.
REQ-016 Address arithmetic is 5-bit unsigned; 12 + error_phase SHALL never exceed 23.

Reset
REQ-017 On reset:
- The state goes to IDLE.
- The row and drain counters, error_phase and both pending flags clear.
- req_drop clears.
- All outputs are 0.
REQ-018 Reset asserted mid-pass SHALL abort the pass immediately: no done pulse, and error_phase is not incremented.

Verification
REQ-019 Forward pass: fwd_start with stall=0 -> active_normal high 12 cycles with tap_address 0..11, active_start_d on address 0, done 5 cycles after the last row, busy low after done.
REQ-020 Error pass: err_start with error_phase=3 -> one cycle error_update_first with tap_address 15, then 12 rows with tap_enable and error_update_latch high, done, then error_phase=4.
REQ-021 Stall in ERR: stall=1 for 3 cycles at row 6 -> tap_address holds at 6, tap_enable low for those cycles, total ERR length 15 cycles, rows 0..11 each issued once.
REQ-022 Arbitration: fwd_start and err_start in the same IDLE cycle -> FWD runs first, then ERR_FIRST on the first IDLE cycle after done; a second err_start during FWD sets req_drop.
REQ-023 Phase wrap: twelve back-to-back error passes from phase 0 -> error_phase returns to 0, and the last pass uses accumulator row 23.
REQ-024 Mid-pass reset: reset at FWD row 7 -> all outputs 0 the next cycle, no done pulse, and a following fwd_start restarts at row 0.

Source files
------------

// File: rtl/four_12_12_st0_tap_sched.sv
// Tap/bias row address scheduler for forward and error-update passes.
// A pass issues NTAP rows (stall-aware), then drains DRAIN cycles before done.
module four_12_12_st0_tap_sched #(
    parameter int NTAP  = 12,
    parameter int DRAIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fwd_start,
    input  logic       err_start,
    input  logic       stall,
    output logic [4:0] tap_address,
    output logic       tap_enable,
    output logic       active_normal,
    output logic       active_start_d,
    output logic       error_update_first,
    output logic       error_update_latch,
    output logic [3:0] error_phase,
    output logic       busy,
    output logic       done,
    output logic       req_drop
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [4:0]    LAST_ROW   = 5'(NTAP - 1);
    localparam logic [4:0]    ACC_BASE   = 5'(NTAP);
    localparam logic [3:0]    LAST_PHASE = 4'(NTAP - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_ERR_FIRST,
        S_ERR,
        S_DRAIN
    } state_t;

    state_t        state_reg, state_next;
    logic [4:0]    row_reg, row_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic [3:0]    phase_reg, phase_next;
    logic          fwd_pend_reg, fwd_pend_next;
    logic          err_pend_reg, err_pend_next;
    logic          drop_reg, drop_next;
    logic          err_pass_reg, err_pass_next;

    logic take_fwd;
    logic take_err;

    // Forward wins in IDLE; a losing error request stays in its pending flag.
    assign take_fwd = (state_reg == S_IDLE) && (fwd_start || fwd_pend_reg);
    assign take_err = (state_reg == S_IDLE) && !take_fwd && (err_start || err_pend_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            row_reg      <= '0;
            drain_reg    <= '0;
            phase_reg    <= '0;
            fwd_pend_reg <= 1'b0;
            err_pend_reg <= 1'b0;
            drop_reg     <= 1'b0;
            err_pass_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            drain_reg    <= drain_next;
            phase_reg    <= phase_next;
            fwd_pend_reg <= fwd_pend_next;
            err_pend_reg <= err_pend_next;
            drop_reg     <= drop_next;
            err_pass_reg <= err_pass_next;
        end
    end

    // Request bookkeeping: a start is either consumed by the pass leaving IDLE
    // or parked in a one-deep flag; a start landing on a full flag is lost.
    always_comb begin
        fwd_pend_next = take_fwd ? 1'b0 : (fwd_pend_reg | fwd_start);
        err_pend_next = take_err ? 1'b0 : (err_pend_reg | err_start);
        drop_next     = drop_reg
                      | (fwd_start & fwd_pend_reg)
                      | (err_start & err_pend_reg);
        err_pass_next = err_pass_reg;
        if (take_fwd) begin
            err_pass_next = 1'b0;
        end else if (take_err) begin
            err_pass_next = 1'b1;
        end
    end

    always_comb begin
        state_next         = state_reg;
        row_next           = row_reg;
        drain_next         = drain_reg;
        phase_next         = phase_reg;
        tap_address        = 5'd0;
        tap_enable         = 1'b0;
        active_normal      = 1'b0;
        active_start_d     = 1'b0;
        error_update_first = 1'b0;
        error_update_latch = 1'b0;
        done               = 1'b0;

        case (state_reg)
            S_IDLE: begin
                row_next   = 5'd0;
                drain_next = '0;
                if (take_fwd) begin
                    state_next = S_FWD;
                end else if (take_err) begin
                    state_next = S_ERR_FIRST;
                end
            end

            S_FWD: begin
                tap_address = row_reg;
                if (!stall) begin
                    active_normal  = 1'b1;
                    active_start_d = (row_reg == 5'd0);
                    if (row_reg == LAST_ROW) begin
                        row_next   = 5'd0;
                        drain_next = '0;
                        state_next = S_DRAIN;
                    end else begin
                        row_next = row_reg + 5'd1;
                    end
                end
            end

            // Accumulator row read; issued regardless of stall.
            S_ERR_FIRST: begin
                error_update_first = 1'b1;
                active_normal      = 1'b1;
                tap_address        = ACC_BASE + {1'b0, phase_reg};
                row_next           = 5'd0;
                state_next         = S_ERR;
            end

            S_ERR: begin
                tap_address = row_reg;
                if (!stall) begin
                    active_normal      = 1'b1;
                    tap_enable         = 1'b1;
                    error_update_latch = 1'b1;
                    if (row_reg == LAST_ROW) begin
                        row_next   = 5'd0;
                        drain_next = '0;
                        state_next = S_DRAIN;
                    end else begin
                        row_next = row_reg + 5'd1;
                    end
                end
            end

            S_DRAIN: begin
                if (drain_reg == LAST_DRAIN) begin
                    done       = 1'b1;
                    drain_next = '0;
                    state_next = S_IDLE;
                    if (err_pass_reg) begin
                        phase_next = (phase_reg == LAST_PHASE) ? 4'd0 : phase_reg + 4'd1;
                    end
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_reg != S_IDLE);
    assign error_phase = phase_reg;
    assign req_drop    = drop_reg;

endmodule

// File: tb/tb_four_12_12_st0_tap_sched.sv
// Bench for the tap scheduler: directed pass table, corner sequences, and a
// randomized run against a pass-level reference model.
module tb_four_12_12_st0_tap_sched;

    localparam int NTAP  = 12;
    localparam int DRAIN = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fwd_start = 1'b0;
    logic       err_start = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] tap_address;
    logic       tap_enable;
    logic       active_normal;
    logic       active_start_d;
    logic       error_update_first;
    logic       error_update_latch;
    logic [3:0] error_phase;
    logic       busy;
    logic       done;
    logic       req_drop;

    four_12_12_st0_tap_sched #(.NTAP(NTAP), .DRAIN(DRAIN)) dut (
        .clk                (clk),
        .reset              (reset),
        .fwd_start          (fwd_start),
        .err_start          (err_start),
        .stall              (stall),
        .tap_address        (tap_address),
        .tap_enable         (tap_enable),
        .active_normal      (active_normal),
        .active_start_d     (active_start_d),
        .error_update_first (error_update_first),
        .error_update_latch (error_update_latch),
        .error_phase        (error_phase),
        .busy               (busy),
        .done               (done),
        .req_drop           (req_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] dut_vec;
    assign dut_vec = {tap_address, tap_enable, active_normal, active_start_d,
                      error_update_first, error_update_latch, error_phase,
                      busy, done, req_drop};

    task automatic check(input string name, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fwd_start = 1'b0;
        err_start = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete pass; reports what was observed so the caller can compare.
    task automatic run_pass(input int kind, input int srow, input int sn,
                            output int act, output int blen, output int ten,
                            output int faddr, output int sd, output int dn,
                            output int issued, output int ok);
        int  sleft;
        bit  first_seen;
        bit  seen_busy;
        bit  fin;
        act = 0; blen = 0; ten = 0; faddr = -1; sd = 0; dn = 0; issued = 0; ok = 1;
        sleft = sn; first_seen = 0; seen_busy = 0; fin = 0;
        fwd_start = (kind == 0);
        err_start = (kind == 1);
        stall = 1'b0;
        tick();
        fwd_start = 1'b0;
        err_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            stall = (issued == srow) && (sleft > 0) && (kind == 0 || first_seen);
            @(negedge clk);
            if (busy) begin
                blen++;
                seen_busy = 1;
            end
            if (active_normal && faddr < 0) faddr = int'(tap_address);
            if (active_normal) act++;
            if (error_update_first) begin
                first_seen = 1;
            end else if (active_normal) begin
                if (int'(tap_address) != issued) ok = 0;
                issued++;
            end
            if (stall) begin
                sleft--;
                if (int'(tap_address) != issued || active_normal || tap_enable ||
                    error_update_latch || active_start_d) ok = 0;
            end
            if (tap_enable) ten++;
            if (active_start_d) sd++;
            if (done) dn++;
            if (seen_busy && !busy) begin
                fin = 1;
                break;
            end
            tick();
        end
        stall = 1'b0;
        if (!fin) check("pass_timeout", 32'd0, 1);
        tick();
    endtask

    typedef struct {
        int kind;   // 0 forward, 1 error
        int srow;   // row at which stall starts (-1: none)
        int sn;     // stall length
        int act;    // expected active_normal cycles
        int blen;   // expected busy cycles
        int ten;    // expected tap_enable cycles
        int faddr;  // expected first issued address
        int phase;  // expected error_phase after the pass
        int sd;     // expected active_start_d pulses
    } vec_t;

    vec_t vt[6];

    // ---- pass-level reference model for the random run ----
    int m_kind;      // -1 no pass, 0 forward, 1 error
    bit m_acc;       // accumulator row already issued in this error pass
    int m_rows;      // rows issued so far in this pass
    int m_drain;     // drain cycles already spent
    int m_phase;
    bit m_pf, m_pe, m_drop;

    function automatic void model_reset();
        m_kind = -1; m_acc = 0; m_rows = 0; m_drain = 0;
        m_phase = 0; m_pf = 0; m_pe = 0; m_drop = 0;
    endfunction

    function automatic logic [16:0] model_step(input bit f, input bit e, input bit s);
        int addr; bit ten, an, sd, euf, eul, dn, bsy, drp;
        int ph;
        addr = 0; ten = 0; an = 0; sd = 0; euf = 0; eul = 0; dn = 0;
        bsy = (m_kind >= 0);
        drp = m_drop;
        ph  = m_phase;
        if ((f && m_pf) || (e && m_pe)) m_drop = 1;
        if (m_kind < 0) begin
            if (f || m_pf) begin
                m_kind = 0; m_rows = 0; m_drain = 0;
                m_pf = 0; m_pe = m_pe | e;
            end else if (e || m_pe) begin
                m_kind = 1; m_acc = 0; m_rows = 0; m_drain = 0;
                m_pe = 0;
            end
        end else begin
            m_pf = m_pf | f;
            m_pe = m_pe | e;
            if (m_kind == 1 && !m_acc) begin
                euf = 1; an = 1; addr = NTAP + m_phase;
                m_acc = 1;
            end else if (m_rows < NTAP) begin
                addr = m_rows;
                if (!s) begin
                    an = 1;
                    sd = (m_kind == 0 && m_rows == 0);
                    if (m_kind == 1) begin
                        ten = 1; eul = 1;
                    end
                    m_rows++;
                end
            end else if (m_drain == DRAIN - 1) begin
                dn = 1;
                if (m_kind == 1) m_phase = (m_phase + 1) % NTAP;
                m_kind = -1;
            end else begin
                m_drain++;
            end
        end
        return {5'(addr), ten, an, sd, euf, eul, 4'(ph), bsy, dn, drp};
    endfunction

    initial begin
        int act, blen, ten, faddr, sd, dn, issued, ok;
        int t_done, t_euf, euf_addr;
        bit got_done, got_euf;
        logic [16:0] exp_vec;
        bit rf, re, rs, rr;

        vt[0] = '{0, -1, 0, 12, 17,  0,  0, 0, 1};
        vt[1] = '{1, -1, 0, 13, 18, 12, 12, 1, 0};
        vt[2] = '{1,  6, 3, 13, 21, 12, 13, 2, 0};
        vt[3] = '{1, -1, 0, 13, 18, 12, 14, 3, 0};
        vt[4] = '{1, -1, 0, 13, 18, 12, 15, 4, 0};
        vt[5] = '{0,  0, 2, 12, 19,  0,  0, 4, 1};

        do_reset();
        @(negedge clk);
        check("reset_outputs", 32'(dut_vec), 0);
        tick();

        // Directed pass table
        for (int i = 0; i < 6; i++) begin
            run_pass(vt[i].kind, vt[i].srow, vt[i].sn, act, blen, ten, faddr, sd, dn, issued, ok);
            $display("vec %0d kind=%0d stall@%0d x%0d: act=%0d busy=%0d ten=%0d faddr=%0d phase=%0d done=%0d",
                     i, vt[i].kind, vt[i].srow, vt[i].sn, act, blen, ten, faddr, error_phase, dn);
            check($sformatf("vec%0d_active", i), 32'(act), vt[i].act);
            check($sformatf("vec%0d_busy_len", i), 32'(blen), vt[i].blen);
            check($sformatf("vec%0d_tap_enable", i), 32'(ten), vt[i].ten);
            check($sformatf("vec%0d_first_addr", i), 32'(faddr), vt[i].faddr);
            check($sformatf("vec%0d_phase", i), 32'(error_phase), vt[i].phase);
            check($sformatf("vec%0d_start_d", i), 32'(sd), vt[i].sd);
            check($sformatf("vec%0d_done", i), 32'(dn), 1);
            check($sformatf("vec%0d_rows", i), 32'(issued), NTAP);
            check($sformatf("vec%0d_order", i), 32'(ok), 1);
        end

        // Arbitration: simultaneous starts, then a dropped second err_start
        do_reset();
        fwd_start = 1'b1;
        err_start = 1'b1;
        tick();
        fwd_start = 1'b0;
        err_start = 1'b0;
        @(negedge clk);
        check("arb_fwd_first_start_d", 32'(active_start_d), 1);
        check("arb_fwd_first_euf", 32'(error_update_first), 0);
        tick();
        tick();
        err_start = 1'b1;
        tick();
        err_start = 1'b0;
        @(negedge clk);
        check("arb_req_drop", 32'(req_drop), 1);
        got_done = 0; got_euf = 0; t_done = 0; t_euf = 0; euf_addr = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done && !got_done) begin
                got_done = 1;
                t_done = c;
            end
            if (error_update_first && !got_euf) begin
                got_euf = 1;
                t_euf = c;
                euf_addr = int'(tap_address);
            end
            tick();
            if (got_euf) break;
        end
        $display("arb: done@%0d euf@%0d addr=%0d", t_done, t_euf, euf_addr);
        check("arb_err_followed", 32'(got_done && got_euf), 1);
        check("arb_done_to_err_first", 32'(t_euf - t_done), 2);
        check("arb_err_first_addr", 32'(euf_addr), NTAP);

        // Phase wrap across twelve error passes
        do_reset();
        for (int p = 0; p < NTAP; p++) begin
            run_pass(1, -1, 0, act, blen, ten, faddr, sd, dn, issued, ok);
            $display("wrap pass %0d: acc_addr=%0d phase_after=%0d", p, faddr, error_phase);
            check($sformatf("wrap%0d_acc_addr", p), 32'(faddr), NTAP + p);
        end
        check("wrap_phase_zero", 32'(error_phase), 0);

        // Reset in the middle of a forward pass
        do_reset();
        fwd_start = 1'b1;
        tick();
        fwd_start = 1'b0;
        got_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (active_normal && tap_address == 5'd7) begin
                got_done = 1;
                break;
            end
            tick();
        end
        check("midrst_reached_row7", 32'(got_done), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        $display("midrst: outputs after reset = %h", dut_vec);
        check("midrst_outputs_zero", 32'(dut_vec), 0);
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst_no_done", 32'(dn), 0);
        tick();
        fwd_start = 1'b1;
        tick();
        fwd_start = 1'b0;
        @(negedge clk);
        check("midrst_restart_addr", 32'(tap_address), 0);
        check("midrst_restart_start_d", 32'(active_start_d), 1);
        tick();

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(399) == 0);
            rf = ($urandom_range(19) == 0);
            re = ($urandom_range(15) == 0);
            rs = ($urandom_range(3) == 0);
            reset = rr;
            fwd_start = rf;
            err_start = re;
            stall = rs;
            @(negedge clk);
            if (rr) begin
                model_reset();
                $display("rand %0d: reset", i);
            end else begin
                exp_vec = model_step(rf, re, rs);
                n_cmp++;
                if (dut_vec !== exp_vec) begin
                    n_bad++;
                    $display("FAIL rand_cycle_%0d: got %h required %h (f=%0d e=%0d s=%0d)",
                             i, dut_vec, exp_vec, rf, re, rs);
                end
            end
            tick();
        end
        reset = 1'b0;
        fwd_start = 1'b0;
        err_start = 1'b0;
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
